serial_add_ctrl: RTL and testbench
==================================

# serial_add_ctrl

Bit-serial addition controller. It sequences a single one-bit full-adder slice over WIDTH cycles to compute a WIDTH-bit sum with carry, trading latency for area against the parallel ripple adder. It sits beside the counter/adder datapath as a start/busy/done-driven arithmetic engine for callers that can tolerate multi-cycle results.

## Interface
- WIDTH, 4, operand and sum width in bits (≥1)
- clk  in  1  rising-edge clock
- rst  in  1  reset, synchronous, active-high
- start  in  1  request; sampled only when busy=0
- x  in  WIDTH  operand A, captured on accepted start
- y  in  WIDTH  operand B, captured on accepted start
- c_in  in  1  carry-in, captured on accepted start
- busy  out  1  high while bits are being processed (RUN)
- done  out  1  one-cycle pulse: s/c_out just updated
- s  out  WIDTH  last completed sum, held between operations
- c_out  out  1  last completed carry-out, held

## Operation
- States: IDLE, RUN, DONE.
- IDLE: busy=0, done=0. start=1 → capture x, y into operand shift registers, c_in into carry flop, clear bit counter, clear sum shift register, → RUN.
- RUN: busy=1. Each cycle the slice adds the operand LSBs and the carry flop. Sum bit shifts into the sum shift register from the MSB end. Operands shift right. Carry flop takes the slice carry. Counter increments.
  - After the cycle processing bit WIDTH-1 → DONE.
  - On that same edge: s ← full sum shift register, c_out ← final carry.
- DONE: done=1, busy=0.
  - start=1 → capture new operands, → RUN (back-to-back supported).
  - start=0 → IDLE.
- start during RUN is ignored and is not queued. x/y/c_in changes during RUN have no effect.
- Result rule: {c_out, s} = x + y + c_in, computed at WIDTH+1 bits. No overflow is possible.
- s and c_out change only on the edge entering DONE. They are stable throughout RUN.
- Reset, including mid-RUN: state=IDLE, busy=0, done=0, s=0, c_out=0, internal shift registers/counter/carry=0. The in-flight operation is discarded.

## Timing
- Accepted start sampled at edge E0.
- busy high in the cycles after E0 … E(WIDTH-1). RUN lasts exactly WIDTH cycles.
- Result registered at edge E(WIDTH). done high in the cycle after E(WIDTH).
- Latency start→done = WIDTH+1 edges. Throughput with back-to-back starts is one result per WIDTH+1 cycles.
- Bit counter width = clog2(WIDTH+1). Terminal compare against WIDTH-1 happens while in RUN.
- All outputs are registered. There is no combinational path from inputs to outputs.

## Structure
- Package serial_add_pkg:
  - state enum {IDLE, RUN, DONE}
  - counter-width helper function
- Sub-module serial_add_slice:
  - one-bit full adder (two half adders + OR), combinational
  - ports: a, b, cin, sum, cout
  - the carry flop lives in the controller so that reset and capture are centralized
- Top level: FSM, counter, operand/sum shift registers, result registers.

## Test plan
- WIDTH=4, x=3, y=5, c_in=0, start one cycle → busy high 4 cycles, done pulse on 5th cycle after start, s=8, c_out=0.
- x=15, y=1, c_in=0 → s=0, c_out=1. Then x=15, y=15, c_in=1 → s=15, c_out=1.
- Start x=2, y=2; pulse start with x=7, y=7 during RUN → ignored, result s=4, c_out=0, single done pulse.
- Start x=9, y=9; assert rst on the 2nd RUN cycle → next cycle busy=0, done=0, s=0, c_out=0, no done pulse follows.
- start held high continuously with new operands each DONE cycle → done every 5 cycles, each result matches its own operands.
- Exhaustive 4-bit x, y, c_in sweep (512 ops) plus random WIDTH=8 ops → {c_out, s} equals the reference sum every time.

Source files
------------

// File: rtl/serial_add_pkg.sv
// Shared types and helpers for the bit-serial adder controller.
package serial_add_pkg;

  // Controller states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Bit-counter width: the counter must reach WIDTH on the edge entering DONE.
  function automatic int cnt_width(input int width);
    int w;
    w = (width < 1) ? 1 : $clog2(width + 1);
    if (w < 1) begin
      w = 1;
    end else begin
      w = w;
    end
    return w;
  endfunction

endpackage

// File: rtl/serial_add_slice.sv
// One-bit full adder built from two half adders and an OR; purely combinational.
// The carry flop lives in the controller so reset and capture stay in one place.
module serial_add_slice (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  logic hs1_s;
  logic hc1_s;
  logic hc2_s;

  // First half adder on the operand bits.
  assign hs1_s = a ^ b;
  assign hc1_s = a & b;

  // Second half adder folds in the carry.
  assign sum   = hs1_s ^ cin;
  assign hc2_s = hs1_s & cin;

  // Either half adder may generate the carry-out.
  assign cout  = hc1_s | hc2_s;

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial addition controller: one full-adder slice is stepped over WIDTH
// cycles, LSB first. The result registers only move on the edge entering DONE,
// so s/c_out hold the previous result for the whole RUN phase.
module serial_add_ctrl #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             c_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] s,
  output logic             c_out
);

  import serial_add_pkg::*;

  localparam int CW = cnt_width(WIDTH);

  state_e           state_r;
  logic [WIDTH-1:0] a_sh_r;
  logic [WIDTH-1:0] b_sh_r;
  logic [WIDTH-1:0] sum_sh_r;
  logic             carry_r;
  logic [CW-1:0]    cnt_r;

  logic             sum_bit_s;
  logic             cout_s;
  logic [WIDTH-1:0] sum_next_s;
  logic             last_bit_s;

  serial_add_slice u_slice (
    .a    (a_sh_r[0]),
    .b    (b_sh_r[0]),
    .cin  (carry_r),
    .sum  (sum_bit_s),
    .cout (cout_s)
  );

  // Next sum register value (new bit enters at the MSB) and terminal-bit detect.
  always_comb begin
    sum_next_s            = sum_sh_r >> 1'b1;
    sum_next_s[WIDTH-1]   = sum_bit_s;
    last_bit_s            = (cnt_r == CW'(WIDTH - 1));
  end

  // Controller FSM with datapath shift registers and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r  <= IDLE;
      a_sh_r   <= '0;
      b_sh_r   <= '0;
      sum_sh_r <= '0;
      carry_r  <= 1'b0;
      cnt_r    <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      s        <= '0;
      c_out    <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            a_sh_r   <= x;
            b_sh_r   <= y;
            carry_r  <= c_in;
            cnt_r    <= '0;
            sum_sh_r <= '0;
            busy     <= 1'b1;
            state_r  <= RUN;
          end else begin
            busy     <= 1'b0;
          end
        end
        RUN: begin
          a_sh_r   <= a_sh_r >> 1'b1;
          b_sh_r   <= b_sh_r >> 1'b1;
          sum_sh_r <= sum_next_s;
          carry_r  <= cout_s;
          cnt_r    <= cnt_r + CW'(1);
          if (last_bit_s) begin
            s       <= sum_next_s;
            c_out   <= cout_s;
            busy    <= 1'b0;
            done    <= 1'b1;
            state_r <= DONE;
          end else begin
            busy    <= 1'b1;
            done    <= 1'b0;
          end
        end
        DONE: begin
          done <= 1'b0;
          if (start) begin
            a_sh_r   <= x;
            b_sh_r   <= y;
            carry_r  <= c_in;
            cnt_r    <= '0;
            sum_sh_r <= '0;
            busy     <= 1'b1;
            state_r  <= RUN;
          end else begin
            busy     <= 1'b0;
            state_r  <= IDLE;
          end
        end
        default: begin
          state_r <= IDLE;
          busy    <= 1'b0;
          done    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Scoreboard bench for serial_add_ctrl: a 4-bit and an 8-bit instance.
// Expected results are plain arithmetic sums pushed at stimulus time and
// popped by a monitor whenever a done pulse appears.
module tb_serial_add_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       start4, c_in4, busy4, done4, c_out4;
  logic [3:0] x4, y4, s4;
  logic       start8, c_in8, busy8, done8, c_out8;
  logic [7:0] x8, y8, s8;

  serial_add_ctrl #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .x(x4), .y(y4), .c_in(c_in4),
    .busy(busy4), .done(done4), .s(s4), .c_out(c_out4)
  );

  serial_add_ctrl #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .x(x8), .y(y8), .c_in(c_in8),
    .busy(busy8), .done(done8), .s(s8), .c_out(c_out8)
  );

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  logic [4:0] exp4_q[$];
  logic [8:0] exp8_q[$];
  logic [4:0] last4 = 5'd0;
  logic [8:0] last8 = 9'd0;
  logic [4:0] e4;
  logic [8:0] e8;
  bit         b2b_chk  = 1'b0;
  int         b2b_prev = -1;

  // Free-running cycle count for done-interval checks.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    n_cmp++;
    if (act !== exp_v) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp_v, $time);
    end
  endtask

  // Monitor: pop and compare on every done pulse; results must hold while busy.
  always @(negedge clk) begin
    if (!rst) begin
      if (done4) begin
        check("done4_busy_low", {31'd0, busy4}, 32'd0);
        if (exp4_q.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL done4_unexpected: got done with result %0h expected no done", {c_out4, s4});
        end else begin
          e4 = exp4_q.pop_front();
          check("result4", {27'd0, c_out4, s4}, {27'd0, e4});
          last4 = e4;
        end
        if (b2b_chk) begin
          if (b2b_prev >= 0) check("b2b_interval", cyc - b2b_prev, 32'd5);
          b2b_prev = cyc;
        end
      end else if (busy4) begin
        check("hold4", {27'd0, c_out4, s4}, {27'd0, last4});
      end
      if (done8) begin
        if (exp8_q.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL done8_unexpected: got done with result %0h expected no done", {c_out8, s8});
        end else begin
          e8 = exp8_q.pop_front();
          check("result8", {23'd0, c_out8, s8}, {23'd0, e8});
          last8 = e8;
        end
      end else if (busy8) begin
        check("hold8", {23'd0, c_out8, s8}, {23'd0, last8});
      end
    end
  end

  task automatic wait_idle(input bit sel8);
    int n;
    n = 0;
    while ((sel8 ? busy8 : busy4) && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    if (sel8 ? busy8 : busy4) begin
      n_cmp++; n_err++;
      $display("FAIL idle_timeout: got busy after 40 cycles expected idle");
    end
  endtask

  // Issue one operation (start held for a single cycle) and record its sum.
  task automatic op(input bit sel8, input logic [7:0] a, input logic [7:0] b, input logic ci);
    wait_idle(sel8);
    if (sel8) begin
      x8 = a; y8 = b; c_in8 = ci; start8 = 1'b1;
      exp8_q.push_back({1'b0, a} + {1'b0, b} + {8'd0, ci});
    end else begin
      x4 = a[3:0]; y4 = b[3:0]; c_in4 = ci; start4 = 1'b1;
      exp4_q.push_back({1'b0, a[3:0]} + {1'b0, b[3:0]} + {4'd0, ci});
    end
    @(posedge clk); #1;
    start4 = 1'b0;
    start8 = 1'b0;
  endtask

  initial begin
    int n;
    logic [7:0] ra, rb;
    rst = 1'b1;
    start4 = 1'b0; x4 = 4'd0; y4 = 4'd0; c_in4 = 1'b0;
    start8 = 1'b0; x8 = 8'd0; y8 = 8'd0; c_in8 = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state of both instances.
    check("rst4_outputs", {25'd0, busy4, done4, c_out4, s4}, 32'd0);
    check("rst8_outputs", {21'd0, busy8, done8, c_out8, s8}, 32'd0);

    // 3+5: busy for exactly 4 cycles, done in the 5th.
    op(1'b0, 8'd3, 8'd5, 1'b0);
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      check("timing_busy", {31'd0, busy4}, (k <= 4) ? 32'd1 : 32'd0);
      check("timing_done", {31'd0, done4}, (k == 5) ? 32'd1 : 32'd0);
    end
    @(posedge clk); #1;

    // Carry-out boundaries.
    op(1'b0, 8'd15, 8'd1, 1'b0);
    op(1'b0, 8'd15, 8'd15, 1'b1);

    // start during RUN must be ignored.
    op(1'b0, 8'd2, 8'd2, 1'b0);
    @(posedge clk); #1;
    x4 = 4'd7; y4 = 4'd7; start4 = 1'b1;
    @(posedge clk); #1;
    start4 = 1'b0;
    repeat (8) @(posedge clk);
    #1;

    // Reset on the 2nd RUN cycle discards the operation.
    wait_idle(1'b0);
    x4 = 4'd9; y4 = 4'd9; c_in4 = 1'b0; start4 = 1'b1;
    @(posedge clk); #1;
    start4 = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    last4 = 5'd0;
    last8 = 9'd0;
    @(negedge clk);
    check("midrst_outputs", {27'd0, busy4, done4, c_out4, s4}, 32'd0);
    repeat (10) @(posedge clk);
    #1;

    // start held high: a new operand set is presented in each DONE cycle.
    wait_idle(1'b0);
    b2b_chk = 1'b1;
    b2b_prev = -1;
    for (int i = 0; i < 6; i++) begin
      ra = 8'($urandom_range(0, 15));
      rb = 8'($urandom_range(0, 15));
      x4 = ra[3:0]; y4 = rb[3:0]; c_in4 = 1'(i % 2); start4 = 1'b1;
      exp4_q.push_back({1'b0, ra[3:0]} + {1'b0, rb[3:0]} + {4'd0, 1'(i % 2)});
      repeat (5) @(posedge clk);
      #1;
    end
    start4 = 1'b0;
    @(negedge clk);
    @(posedge clk); #1;
    b2b_chk = 1'b0;

    // Exhaustive 4-bit sweep.
    for (int xa = 0; xa < 16; xa++)
      for (int ya = 0; ya < 16; ya++)
        for (int ci = 0; ci < 2; ci++)
          op(1'b0, 8'(xa), 8'(ya), 1'(ci));

    // Random 8-bit operations with occasional idle gaps.
    for (int i = 0; i < 150; i++) begin
      op(1'b1, 8'($urandom), 8'($urandom), 1'($urandom));
      if ($urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(1, 4)) @(posedge clk);
        #1;
      end
    end

    // Drain the scoreboard.
    n = 0;
    while ((exp4_q.size() != 0 || exp8_q.size() != 0) && n < 100) begin
      @(posedge clk);
      n++;
    end
    @(negedge clk);
    if (exp4_q.size() != 0 || exp8_q.size() != 0) begin
      n_cmp++; n_err++;
      $display("FAIL drain: got %0d/%0d results outstanding expected 0", exp4_q.size(), exp8_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
